// File: rtl/tdm_mux_pkg.sv
// Shared constants and types for the tdm_mux time-division multiplexer.
package tdm_mux_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    // Smallest r with 2**r >= n; used to sanity-check the select width.
    function automatic int tdm_clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/tdm_mux_next_sel.sv
// Next-enabled-channel finder: searches base+1, base+2, ... with wrap at CH.
module tdm_mux_next_sel
    import tdm_mux_pkg::*;
#(
    parameter int CH    = 4,
    parameter int SEL_W = 2
) (
    input  logic [SEL_W-1:0] base,
    input  logic [CH-1:0]    en,
    output logic [SEL_W-1:0] nxt,
    output logic             any
);

    localparam int               NP   = 2 ** (SEL_W + 1);
    localparam logic [SEL_W:0]   CH_W = (SEL_W + 1)'(CH);

    logic [NP-1:0]  en_pad;
    logic [SEL_W:0] b;
    logic [SEL_W:0] c;
    logic           found;
    logic           in_range;

    always_comb begin
        en_pad       = '0;
        en_pad[CH-1:0] = en;
        in_range     = ({1'b0, base} < CH_W);
        // An out-of-range base starts the search at channel 0.
        b            = in_range ? {1'b0, base} : CH_W - 1'b1;
        nxt          = in_range ? base : '0;
        found        = 1'b0;
        c            = '0;
        for (int i = 1; i <= CH; i++) begin
            c = b + (SEL_W + 1)'(i);
            if (c >= CH_W) c = c - CH_W;
            if (!found && en_pad[c]) begin
                nxt   = c[SEL_W-1:0];
                found = 1'b1;
            end
        end
        any = |en;
    end

endmodule

// File: rtl/tdm_mux.sv
// N-channel W-bit TDM mux with registered valid/ready output and auto-scan.
// Optional per-channel enable mask is compiled in with TDM_MUX_MASK_EN.
module tdm_mux
    import tdm_mux_pkg::*;
#(
    parameter int CH      = 4,
    parameter int W       = 1,
    parameter int SEL_W   = 2,
    parameter int DWELL_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CH*W-1:0]     d,
    input  logic [SEL_W-1:0]    s,
    input  logic                mode,
    input  logic [DWELL_W-1:0]  dwell,
`ifdef TDM_MUX_MASK_EN
    input  logic [CH-1:0]       en_mask,
`endif
    output logic [W-1:0]        y,
    output logic                y_valid,
    input  logic                y_ready,
    output logic [SEL_W-1:0]    cur_sel
);

    localparam int             NSEL = 2 ** SEL_W;
    localparam logic [SEL_W:0] CH_W = (SEL_W + 1)'(CH);

    if (SEL_W < tdm_clog2(CH) || CH < 2 || CH > 16) begin : g_bad_cfg
        $error("tdm_mux: CH must be 2..16 and 2**SEL_W >= CH");
    end

    // Channel data and enables padded to the full select range; padding reads as 0/disabled.
    logic [W-1:0]    chan [NSEL];
    logic [NSEL-1:0] en_full;
    logic [CH-1:0]   en_ch;

`ifdef TDM_MUX_MASK_EN
    assign en_ch = en_mask;
`else
    assign en_ch = '1;
`endif

    for (genvar k = 0; k < NSEL; k++) begin : g_chan
        if (k < CH) begin : g_real
            assign chan[k]    = d[k*W +: W];
            assign en_full[k] = en_ch[k];
        end else begin : g_pad
            assign chan[k]    = '0;
            assign en_full[k] = 1'b0;
        end
    end

    state_t             state, state_nx;
    logic               mode_q;
    logic [SEL_W-1:0]   ptr, ptr_nx;
    logic [DWELL_W-1:0] cnt, cnt_nx;
    logic               accept, slot_free, entry, advance, load_ok, load;
    logic [SEL_W-1:0]   base, nxt, idx;
    logic               any;

    assign y_valid   = (state == ST_HOLD);
    assign accept    = y_valid && y_ready;
    assign slot_free = !y_valid || y_ready;
    assign entry     = (mode == MODE_SCAN) && (mode_q == MODE_MANUAL);
    assign advance   = accept && (cnt == dwell);
    assign base      = entry ? s : ptr;

    tdm_mux_next_sel #(
        .CH    (CH),
        .SEL_W (SEL_W)
    ) u_next_sel (
        .base (base),
        .en   (en_ch),
        .nxt  (nxt),
        .any  (any)
    );

    always_comb begin
        idx     = s;
        load_ok = 1'b0;
        ptr_nx  = ptr;
        cnt_nx  = '0;
        if (mode == MODE_SCAN) begin
            // A disabled scan channel (or a due advance) moves on to the next enabled one.
            if (entry ? !en_full[s] : (advance || !en_full[ptr])) idx = nxt;
            else                                                  idx = base;
            load_ok = any && en_full[idx];
            ptr_nx  = idx;
            if (entry || advance || !en_full[ptr]) cnt_nx = '0;
            else if (accept)                       cnt_nx = cnt + DWELL_W'(1);
            else                                   cnt_nx = cnt;
        end else begin
            // Out-of-range manual selects still load, presenting 0.
            load_ok = ({1'b0, s} >= CH_W) || en_full[s];
        end
        load = slot_free && load_ok;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_LOAD: if (load) state_nx = ST_HOLD;
            ST_HOLD: if (accept && !load) state_nx = ST_LOAD;
            default: state_nx = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_LOAD;
        else     state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y       <= '0;
            cur_sel <= '0;
            ptr     <= '0;
            cnt     <= '0;
            mode_q  <= MODE_MANUAL;
        end else begin
            mode_q <= mode;
            ptr    <= ptr_nx;
            cnt    <= cnt_nx;
            if (load) begin
                y       <= chan[idx];
                cur_sel <= idx;
            end
        end
    end

endmodule

// File: tb/tb_tdm_mux.sv
// Directed bench for tdm_mux (CH=4, W=8): vector table plus scan/mask sequences.
module tb_tdm_mux;

    localparam int CH = 4, W = 8, SEL_W = 2, DWELL_W = 4;
    localparam logic [31:0] D0 = 32'h44332211;
    localparam logic [31:0] D1 = 32'hDDCCBBAA;

    logic               clk = 1'b0;
    logic               rst, mode, y_ready, y_valid;
    logic [CH*W-1:0]    d;
    logic [SEL_W-1:0]   s, cur_sel;
    logic [DWELL_W-1:0] dwell;
    logic [W-1:0]       y;
`ifdef TDM_MUX_MASK_EN
    logic [CH-1:0]      en_mask;
`endif

    always #5 clk = ~clk;

    tdm_mux #(.CH(CH), .W(W), .SEL_W(SEL_W), .DWELL_W(DWELL_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .d       (d),
        .s       (s),
        .mode    (mode),
        .dwell   (dwell),
`ifdef TDM_MUX_MASK_EN
        .en_mask (en_mask),
`endif
        .y       (y),
        .y_valid (y_valid),
        .y_ready (y_ready),
        .cur_sel (cur_sel)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        rst;
        logic        mode;
        logic [1:0]  s;
        logic        rdy;
        logic [3:0]  dwell;
        logic [31:0] d;
        logic [7:0]  ey;
        logic        ev;
        logic [1:0]  esel;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic m, input logic [1:0] sv, input logic rd,
                                input logic [3:0] dw, input logic [31:0] dv,
                                input logic [7:0] ey, input logic ev, input logic [1:0] es);
        vec_t v;
        v.rst = r; v.mode = m; v.s = sv; v.rdy = rd; v.dwell = dw; v.d = dv;
        v.ey = ey; v.ev = ev; v.esel = es;
        return v;
    endfunction

    initial begin
        int exp_ch;
        int acc;
        rst = 1'b1; mode = 1'b0; s = '0; y_ready = 1'b1; dwell = '0; d = D0;
`ifdef TDM_MUX_MASK_EN
        en_mask = 4'hF;
`endif
        // Reset, manual stepping, back-pressure, mid-stream reset.
        tbl.push_back(mk(1, 0, 0, 1, 0, D0, 8'h00, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, D0, 8'h11, 1, 0));
        tbl.push_back(mk(0, 0, 1, 1, 0, D0, 8'h22, 1, 1));
        tbl.push_back(mk(0, 0, 2, 1, 0, D0, 8'h33, 1, 2));
        tbl.push_back(mk(0, 0, 3, 1, 0, D0, 8'h44, 1, 3));
        for (int k = 0; k < 5; k++)
            tbl.push_back(mk(0, 0, 2'(k), 0, 0, (k % 2) ? D1 : D0, 8'h44, 1, 3));
        tbl.push_back(mk(0, 0, 1, 1, 0, D1, 8'hBB, 1, 1));
        tbl.push_back(mk(1, 0, 3, 0, 0, D0, 8'h00, 0, 0));
        tbl.push_back(mk(1, 0, 3, 0, 0, D0, 8'h00, 0, 0));
        tbl.push_back(mk(0, 0, 2, 0, 0, D0, 8'h33, 1, 2));
        // Scan with dwell=2: three samples per channel, no bubbles.
        for (int k = 0; k < 13; k++) begin
            int ch;
            ch = (k / 3) % 4;
            tbl.push_back(mk(0, 1, 0, 1, 2, D0, 8'(8'h11 * (ch + 1)), 1, 2'(ch)));
        end
        tbl.push_back(mk(0, 0, 2, 1, 0, D0, 8'h33, 1, 2));

        foreach (tbl[i]) begin
            rst = tbl[i].rst; mode = tbl[i].mode; s = tbl[i].s; y_ready = tbl[i].rdy;
            dwell = tbl[i].dwell; d = tbl[i].d;
            tick();
            chk($sformatf("vec%0d_y", i), 32'(y), 32'(tbl[i].ey));
            chk($sformatf("vec%0d_valid", i), 32'(y_valid), 32'(tbl[i].ev));
            chk($sformatf("vec%0d_sel", i), 32'(cur_sel), 32'(tbl[i].esel));
        end

        // Scan, dwell=0, random back-pressure: accepted samples walk 0,1,2,3,0...
        mode = 1'b1; s = '0; y_ready = 1'b1; dwell = '0; d = D0;
        tick();
        chk("scan_entry_sel", 32'(cur_sel), 32'd0);
        exp_ch = 0;
        acc = 0;
        for (int k = 0; k < 24; k++) begin
            y_ready = 1'($urandom_range(0, 1));
            if (y_valid && y_ready) begin
                chk($sformatf("rnd_acc%0d_sel", acc), 32'(cur_sel), 32'(exp_ch));
                chk($sformatf("rnd_acc%0d_y", acc), 32'(y), 32'(8'h11 * (exp_ch + 1)));
                exp_ch = (exp_ch + 1) % 4;
                acc++;
            end
            tick();
            chk($sformatf("rnd%0d_valid", k), 32'(y_valid), 32'd1);
        end
        chk("rnd_any_accepts", 32'(acc > 0), 32'd1);

`ifdef TDM_MUX_MASK_EN
        // Mask 1010: scan alternates 1,3; then all masked drains and stays idle.
        en_mask = 4'b1010; mode = 1'b0; s = 2'd1; y_ready = 1'b1;
        tick();
        chk("mask_manual_sel", 32'(cur_sel), 32'd1);
        mode = 1'b1;
        tick();
        chk("mask_entry_sel", 32'(cur_sel), 32'd1);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("mask_scan%0d_sel", k), 32'(cur_sel), (k % 2 == 0) ? 32'd3 : 32'd1);
            chk($sformatf("mask_scan%0d_y", k), 32'(y), (k % 2 == 0) ? 32'h44 : 32'h22);
        end
        en_mask = 4'b0000;
        tick();
        chk("mask_none_drain", 32'(y_valid), 32'd0);
        tick();
        chk("mask_none_idle", 32'(y_valid), 32'd0);
        en_mask = 4'b0100;
        tick();
        chk("mask_resume_valid", 32'(y_valid), 32'd1);
        chk("mask_resume_sel", 32'(cur_sel), 32'd2);
        chk("mask_resume_y", 32'(y), 32'h33);
        mode = 1'b0; s = 2'd0;
        tick();
        chk("mask_manual_blocked", 32'(y_valid), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
